// File: rtl/uart_rx_frame_if.sv
// Consumer-side handshake of the UART receive framer: received word, valid/ack
// and the per-frame status flags.
interface uart_rx_frame_if #(
   parameter int DATA_BITS = 8
) ();
   logic [DATA_BITS-1:0] data;
   logic                 data_valid;
   logic                 rd_ack;
   logic                 frame_err;
   logic                 parity_err;
   logic                 overrun;

   modport master (
      output data,
      output data_valid,
      output frame_err,
      output parity_err,
      output overrun,
      input  rd_ack
   );

   modport slave (
      input  data,
      input  data_valid,
      input  frame_err,
      input  parity_err,
      input  overrun,
      output rd_ack
   );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receive framer: synchronises rx, steers the bit-tick generator from the
// start edge and samples start/data/parity/stop bits on its mid-bit strobe.
module uart_rx_frame #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            rx,
   input  logic            rx_read,
   input  logic            counter_en,
   output logic            tick_en,
   output logic            tick_rstn,
   output logic            busy,
   uart_rx_frame_if.master rx_bus
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   localparam logic [3:0] LAST_BIT    = 4'(DATA_BITS - 1);
   localparam logic       PAR_ODD_BIT = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
   localparam logic       HAS_PARITY  = (PARITY_EN != 0) ? 1'b1 : 1'b0;

   function automatic logic parity_of(input logic [DATA_BITS-1:0] v);
      return ^v;
   endfunction

   state_t               state_q, state_d;
   logic                 sync1_q, rx_s_q, rx_p_q;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_err_q, par_err_d;
   logic                 got_read_q, got_read_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 data_valid_q, data_valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 parity_err_q, parity_err_d;
   logic                 overrun_q, overrun_d;
   logic                 tick_en_q, tick_rstn_q, busy_q;
   logic                 start_s;
   logic                 ack_s;

   assign start_s = rx_p_q & ~rx_s_q;
   assign ack_s   = rx_bus.rd_ack & data_valid_q;

   // Next-state and datapath computation for the framer.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      par_err_d    = par_err_q;
      got_read_d   = got_read_q;
      data_d       = data_q;
      data_valid_d = data_valid_q & ~ack_s;
      overrun_d    = overrun_q & ~ack_s;
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;

      if (state_q == ST_IDLE) begin
         if (start_s) begin
            state_d    = ST_START;
            bit_cnt_d  = 4'd0;
            shift_d    = '0;
            par_err_d  = 1'b0;
            got_read_d = 1'b0;
         end else begin
            state_d = ST_IDLE;
         end
      end else if (rx_read) begin
         got_read_d = 1'b1;
         case (state_q)
            ST_START: begin
               state_d = rx_s_q ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
               shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
               end else begin
                  state_d = ST_DATA;
               end
            end
            ST_PARITY: begin
               par_err_d = rx_s_q ^ parity_of(shift_q) ^ PAR_ODD_BIT;
               state_d   = ST_STOP;
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               if (rx_s_q) begin
                  // A simultaneous ack frees the slot, so only an unacked word overruns.
                  data_d       = shift_q;
                  data_valid_d = 1'b1;
                  parity_err_d = par_err_q;
                  overrun_d    = overrun_d | (data_valid_q & ~rx_bus.rd_ack);
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else if (counter_en) begin
         // End of bit with no mid-bit sample means the generator is misconfigured.
         if (got_read_q) begin
            got_read_d = 1'b0;
         end else begin
            state_d = ST_IDLE;
         end
      end else begin
         got_read_d = got_read_q;
      end
   end

   // State, synchroniser and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q      <= 1'b1;
         rx_s_q       <= 1'b1;
         rx_p_q       <= 1'b1;
         state_q      <= ST_IDLE;
         bit_cnt_q    <= 4'd0;
         shift_q      <= '0;
         par_err_q    <= 1'b0;
         got_read_q   <= 1'b0;
         data_q       <= '0;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
         tick_en_q    <= 1'b0;
         tick_rstn_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         sync1_q      <= rx;
         rx_s_q       <= sync1_q;
         rx_p_q       <= rx_s_q;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         par_err_q    <= par_err_d;
         got_read_q   <= got_read_d;
         data_q       <= data_d;
         data_valid_q <= data_valid_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         overrun_q    <= overrun_d;
         tick_en_q    <= (state_d != ST_IDLE);
         tick_rstn_q  <= (state_d != ST_IDLE);
         busy_q       <= (state_d != ST_IDLE);
      end
   end

   assign tick_en           = tick_en_q;
   assign tick_rstn         = tick_rstn_q;
   assign busy              = busy_q;
   assign rx_bus.data       = data_q;
   assign rx_bus.data_valid = data_valid_q;
   assign rx_bus.frame_err  = frame_err_q;
   assign rx_bus.parity_err = parity_err_q;
   assign rx_bus.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: an 8N1 instance and an 8E1 instance, each
// driven by a 16-clk-per-bit tick generator model.
module tb_uart_rx_frame;

   logic       clk = 1'b0;
   logic       rstn;
   logic [1:0] rx;
   logic [1:0] rx_read, counter_en, tick_en, tick_rstn, busy;
   logic [3:0] cnt0 = 4'd0;
   logic [3:0] cnt1 = 4'd0;
   int         n_checks = 0;
   int         n_fail   = 0;
   logic       pre_valid;

   always #5 clk = ~clk;

   uart_rx_frame_if #(.DATA_BITS(8)) bus0 ();
   uart_rx_frame_if #(.DATA_BITS(8)) bus1 ();

   uart_rx_frame #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
      .clk(clk), .rstn(rstn), .rx(rx[0]), .rx_read(rx_read[0]),
      .counter_en(counter_en[0]), .tick_en(tick_en[0]), .tick_rstn(tick_rstn[0]),
      .busy(busy[0]), .rx_bus(bus0.master)
   );

   uart_rx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
      .clk(clk), .rstn(rstn), .rx(rx[1]), .rx_read(rx_read[1]),
      .counter_en(counter_en[1]), .tick_en(tick_en[1]), .tick_rstn(tick_rstn[1]),
      .busy(busy[1]), .rx_bus(bus1.master)
   );

   // Tick generator models (SIZE=16): mid-bit strobe at count 7, end-of-bit at 15.
   always @(posedge clk) begin
      if (!tick_rstn[0]) cnt0 <= 4'd0;
      else if (tick_en[0]) cnt0 <= cnt0 + 4'd1;
      if (!tick_rstn[1]) cnt1 <= 4'd0;
      else if (tick_en[1]) cnt1 <= cnt1 + 4'd1;
   end

   assign rx_read[0]    = tick_en[0] && (cnt0 == 4'd7);
   assign counter_en[0] = tick_en[0] && (cnt0 == 4'd15);
   assign rx_read[1]    = tick_en[1] && (cnt1 == 4'd7);
   assign counter_en[1] = tick_en[1] && (cnt1 == 4'd15);

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input int i, input logic b);
      rx[i] = b;
      repeat (16) @(negedge clk);
   endtask

   task automatic send_head(input int i, input logic [7:0] d, input bit par, input logic pbit);
      send_bit(i, 1'b0);
      for (int k = 0; k < 8; k++) send_bit(i, d[k]);
      if (par) send_bit(i, pbit);
   endtask

   // Drive the stop level, wait for its mid-bit strobe, step to the load edge.
   task automatic finish_stop(input int i, input logic sbit, input bit ack_at_load,
                              output logic pre_v);
      bit found = 1'b0;
      rx[i] = sbit;
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         if (rx_read[i]) begin
            found = 1'b1;
            break;
         end
      end
      check_eq("stop_read_seen", 32'(found), 32'd1);
      pre_v = (i == 0) ? bus0.data_valid : bus1.data_valid;
      if (ack_at_load) begin
         if (i == 0) bus0.rd_ack = 1'b1;
         else bus1.rd_ack = 1'b1;
      end
      @(negedge clk);
      bus0.rd_ack = 1'b0;
      bus1.rd_ack = 1'b0;
   endtask

   task automatic ack0();
      bus0.rd_ack = 1'b1;
      @(negedge clk);
      bus0.rd_ack = 1'b0;
   endtask

   task automatic idle(input int n);
      rx = 2'b11;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rstn = 1'b0;
      rx = 2'b11;
      bus0.rd_ack = 1'b0;
      bus1.rd_ack = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_data", 32'(bus0.data), 32'h00);
      check_eq("rst_valid", 32'(bus0.data_valid), 32'd0);
      check_eq("rst_tick", 32'({tick_en[0], tick_rstn[0], busy[0]}), 32'd0);
      rstn = 1'b1;
      idle(4);

      // 0xA5 8N1
      send_head(0, 8'hA5, 1'b0, 1'b0);
      finish_stop(0, 1'b1, 1'b0, pre_valid);
      check_eq("a5_pre_valid", 32'(pre_valid), 32'd0);
      check_eq("a5_data", 32'(bus0.data), 32'hA5);
      check_eq("a5_valid", 32'(bus0.data_valid), 32'd1);
      check_eq("a5_errs", 32'({bus0.frame_err, bus0.parity_err, bus0.overrun}), 32'd0);
      idle(6);
      ack0();
      check_eq("a5_ack_valid", 32'(bus0.data_valid), 32'd0);

      // two-cycle glitch on idle line
      rx[0] = 1'b0;
      repeat (2) @(negedge clk);
      rx[0] = 1'b1;
      repeat (5) @(negedge clk);
      check_eq("glitch_busy", 32'(busy[0]), 32'd1);
      repeat (15) @(negedge clk);
      check_eq("glitch_idle", 32'({busy[0], tick_rstn[0]}), 32'd0);
      check_eq("glitch_valid", 32'(bus0.data_valid), 32'd0);
      idle(4);

      // 0x3C with stop bit low
      send_head(0, 8'h3C, 1'b0, 1'b0);
      finish_stop(0, 1'b0, 1'b0, pre_valid);
      check_eq("fe_pulse", 32'(bus0.frame_err), 32'd1);
      check_eq("fe_valid", 32'(bus0.data_valid), 32'd0);
      check_eq("fe_data", 32'(bus0.data), 32'hA5);
      @(negedge clk);
      check_eq("fe_pulse_end", 32'(bus0.frame_err), 32'd0);
      idle(20);

      // back-to-back 0x11, 0x22 without ack
      send_head(0, 8'h11, 1'b0, 1'b0);
      finish_stop(0, 1'b1, 1'b0, pre_valid);
      check_eq("b2b_first", 32'({bus0.data_valid, bus0.overrun, bus0.data}), 32'h211);
      idle(6);
      send_head(0, 8'h22, 1'b0, 1'b0);
      finish_stop(0, 1'b1, 1'b0, pre_valid);
      check_eq("b2b_data", 32'(bus0.data), 32'h22);
      check_eq("b2b_overrun", 32'({bus0.data_valid, bus0.overrun}), 32'd3);
      idle(6);
      ack0();
      check_eq("b2b_ack", 32'({bus0.data_valid, bus0.overrun}), 32'd0);

      // ack coinciding with a new good frame
      send_head(0, 8'h44, 1'b0, 1'b0);
      finish_stop(0, 1'b1, 1'b0, pre_valid);
      idle(6);
      send_head(0, 8'h33, 1'b0, 1'b0);
      finish_stop(0, 1'b1, 1'b1, pre_valid);
      check_eq("ackload", 32'({bus0.data_valid, bus0.overrun, bus0.data}), 32'h233);
      idle(6);
      ack0();

      // 8E1: 0x07 with parity bit 0 is a mismatch, 0x03 with 0 is good
      send_head(1, 8'h07, 1'b1, 1'b0);
      finish_stop(1, 1'b1, 1'b0, pre_valid);
      check_eq("par_pulse", 32'(bus1.parity_err), 32'd1);
      check_eq("par_data", 32'({bus1.data_valid, bus1.data}), 32'h107);
      @(negedge clk);
      check_eq("par_pulse_end", 32'(bus1.parity_err), 32'd0);
      idle(6);
      bus1.rd_ack = 1'b1;
      @(negedge clk);
      bus1.rd_ack = 1'b0;
      send_head(1, 8'h03, 1'b1, 1'b0);
      finish_stop(1, 1'b1, 1'b0, pre_valid);
      check_eq("par_ok", 32'({bus1.parity_err, bus1.data_valid, bus1.data}), 32'h103);
      idle(6);

      // reset during data bit 3
      send_bit(0, 1'b0);
      for (int k = 0; k < 3; k++) send_bit(0, 1'b1);
      rx[0] = 1'b0;
      repeat (8) @(negedge clk);
      check_eq("mid_busy", 32'(busy[0]), 32'd1);
      rstn = 1'b0;
      #1;
      check_eq("mid_rst_data", 32'(bus0.data), 32'h00);
      check_eq("mid_rst_flags", 32'({bus0.data_valid, bus0.overrun, busy[0], tick_en[0], tick_rstn[0]}), 32'd0);
      rx = 2'b11;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      idle(4);
      send_head(0, 8'h5A, 1'b0, 1'b0);
      finish_stop(0, 1'b1, 1'b0, pre_valid);
      check_eq("after_rst", 32'({bus0.frame_err, bus0.data_valid, bus0.data}), 32'h15A);
      idle(8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
